sync_fifo_flex: RTL and testbench

SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_mem.sv | 40 ++++
 rtl/sync_fifo_flex.sv | 144 ++++++++++++++
 tb/tb_sync_fifo_flex.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the sync_fifo_flex slice: the read-mode enum and
//   the helpers that derive address and occupancy widths from a depth.
//   Pointers carry one extra wrap bit, so the occupancy width is
//   addr width + 1, which is wide enough to hold the value DEPTH.
// -----------------------------------------------------------------------------
package fifo_pkg;

   typedef enum logic {
      FWFT_OFF = 1'b0,   // registered read, one cycle of read latency
      FWFT_ON  = 1'b1    // head word shown on data_out while not empty
   } fwft_mode_e;

   function automatic int fifo_addr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
//   DEPTH x DATA_WIDTH storage for the FIFO. One synchronous write port and
//   one asynchronous read port, so the FIFO can show the head word with no
//   latency in first-word-fall-through mode.
//
//   Ports
//     i_clk      clock, write happens on the rising edge
//     i_wr_en    write strobe (already qualified by the FIFO)
//     i_wr_addr  write address
//     i_wr_data  write data
//     i_rd_addr  read address
//     o_rd_data  word stored at i_rd_addr
// -----------------------------------------------------------------------------
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AW         = fifo_addr_w(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_wr_en,
   input  logic [AW-1:0]         i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [AW-1:0]         i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// sync_fifo_flex
//   Single-clock FIFO with selectable read mode, almost-full/empty flags and
//   sticky overflow/underflow error flags.
//
//   Handshake: wr_en is a write request that is taken on a rising edge only
//   when full is low at that edge; rd_en is a read request taken only when
//   empty is low at that edge. A request against full/empty is dropped (no
//   state change) and raises the matching sticky error flag instead.
//
//   Ports
//     clk           sole clock, rising edge
//     rst           synchronous active-high reset
//     wr_en         write request
//     rd_en         read request
//     data_in       write data
//     clr_err       clears overflow/underflow on the next edge
//     data_out      read data (registered or fall-through, see FWFT)
//     full, empty   count == DEPTH / count == 0
//     almost_full   count >= AF_LEVEL
//     almost_empty  count <= AE_LEVEL
//     count         current occupancy
//     overflow      sticky: write attempted while full
//     underflow     sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_flex
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic                          rd_en,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          clr_err,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [fifo_cnt_w(DEPTH)-1:0]  count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int              AW      = fifo_addr_w(DEPTH);
   localparam int              CW      = fifo_cnt_w(DEPTH);
   localparam fwft_mode_e      C_MODE  = (FWFT != 0) ? FWFT_ON : FWFT_OFF;
   localparam logic [CW-1:0]   C_ONE   = CW'(1);
   localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0]   C_AF    = CW'(AF_LEVEL);
   localparam logic [CW-1:0]   C_AE    = CW'(AE_LEVEL);

   logic [CW-1:0]         r_wr_ptr;
   logic [CW-1:0]         r_rd_ptr;
   logic [CW-1:0]         w_count;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [DATA_WIDTH-1:0] w_head;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_ovf;
   logic                  r_udf;

   // Occupancy falls out of the wrap-bit pointers with plain modulo
   // subtraction; wr_ptr never runs more than DEPTH ahead of rd_ptr.
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_full  = (w_count == C_DEPTH);
   assign w_empty = (w_count == '0);

   // Acceptance uses pre-edge full/empty, so full+rd+wr reads only and
   // empty+rd+wr writes only. Reset blocks the memory write as well.
   assign w_wr_acc = wr_en && !w_full  && !rst;
   assign w_rd_acc = rd_en && !w_empty && !rst;

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .i_clk     (clk),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr[AW-1:0]),
      .i_wr_data (data_in),
      .i_rd_addr (r_rd_ptr[AW-1:0]),
      .o_rd_data (w_head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_ONE;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + C_ONE;
      end
   end

   // A fresh error event outranks clr_err in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (wr_en && w_full) r_ovf <= 1'b1;
         else if (clr_err)    r_ovf <= 1'b0;
         if (rd_en && w_empty) r_udf <= 1'b1;
         else if (clr_err)     r_udf <= 1'b0;
      end
   end

   generate
      if (C_MODE == FWFT_OFF) begin : g_reg_read
         always_ff @(posedge clk) begin
            if (rst)           r_dout <= '0;
            else if (w_rd_acc) r_dout <= w_head;
         end
         assign data_out = r_dout;
      end else begin : g_fwft_read
         // r_dout tracks the head while data is present so that, once the
         // FIFO drains, data_out keeps showing the last word it presented.
         always_ff @(posedge clk) begin
            if (rst)           r_dout <= '0;
            else if (!w_empty) r_dout <= w_head;
         end
         assign data_out = w_empty ? r_dout : w_head;
      end
   endgenerate

   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (w_count >= C_AF);
   assign almost_empty = (w_count <= C_AE);
   assign count        = w_count;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flex
//   Drives one registered-read and one fall-through instance with identical
//   stimulus. A queue model gives occupancy, flags and expected read data;
//   read words go into per-instance expected queues that monitors pop when a
//   read is taken.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flex;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   // ---------------- clock / reset / DUT signals ----------------
   logic          clk = 1'b0;
   logic          rst, wr_en, rd_en, clr_err;
   logic [DW-1:0] data_in;

   logic [DW-1:0] dout0, dout1;
   logic          full0, empty0, af0, ae0, ovf0, udf0;
   logic          full1, empty1, af1, ae1, ovf1, udf1;
   logic [4:0]    cnt0, cnt1;

   always #5 clk = ~clk;

   sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_dut_reg (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .clr_err(clr_err),
      .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
      .count(cnt0), .overflow(ovf0), .underflow(udf0));

   sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_dut_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .clr_err(clr_err),
      .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
      .count(cnt1), .overflow(ovf1), .underflow(udf1));

   // ---------------- model and scoreboard state ----------------
   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] exp_q0[$];
   logic [DW-1:0] exp_q1[$];
   logic          m_ovf   = 1'b0;
   logic          m_udf   = 1'b0;
   logic          m_racc  = 1'b0;
   logic [DW-1:0] m_dout0 = '0;
   logic [DW-1:0] m_hold1 = '0;
   logic [DW-1:0] d1_snap;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT state after the last edge with the model.
   task automatic check_state();
      int n;
      n = model_q.size();
      chk("count",        32'(cnt0), 32'(n));
      chk("full",         32'(full0), 32'(n == DEPTH));
      chk("empty",        32'(empty0), 32'(n == 0));
      chk("almost_full",  32'(af0), 32'(n >= AF));
      chk("almost_empty", 32'(ae0), 32'(n <= AE));
      chk("overflow",     32'(ovf0), 32'(m_ovf));
      chk("underflow",    32'(udf0), 32'(m_udf));
      chk("dout_reg",     32'(dout0), 32'(m_dout0));
      if (n > 0) m_hold1 = model_q[0];
      chk("dout_fwft",    32'(dout1), 32'(m_hold1));
      chk("count_fwft",   32'(cnt1), 32'(n));
      chk("flags_fwft",   {28'd0, full1, empty1, af1, ae1}, {28'd0, n == DEPTH, n == 0, n >= AF, n <= AE});
      chk("err_fwft",     {30'd0, ovf1, udf1}, {30'd0, m_ovf, m_udf});
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic w, input logic r, input logic c, input logic x, input logic [DW-1:0] d);
      logic wacc, racc;
      wr_en = w; rd_en = r; clr_err = c; rst = x; data_in = d;
      if (x) begin
         model_q.delete();
         m_ovf = 1'b0; m_udf = 1'b0; m_racc = 1'b0;
         m_dout0 = '0; m_hold1 = '0;
      end else begin
         wacc = w && (model_q.size() < DEPTH);
         racc = r && (model_q.size() > 0);
         m_racc = racc;
         if (w && model_q.size() == DEPTH) m_ovf = 1'b1;
         else if (c)                       m_ovf = 1'b0;
         if (r && model_q.size() == 0)     m_udf = 1'b1;
         else if (c)                       m_udf = 1'b0;
         if (racc) begin
            m_dout0 = model_q.pop_front();
            exp_q0.push_back(m_dout0);
            exp_q1.push_back(m_dout0);
         end
         if (wacc) model_q.push_back(d);
      end
      @(negedge clk);
      check_state();
   endtask

   // ---------------- monitors ----------------
   // Registered mode: the popped word appears just after the accepting edge.
   initial forever begin
      @(posedge clk);
      if (m_racc) begin
         #2;
         if (exp_q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL scb_reg: read with empty expected queue at t=%0t", $time);
         end else begin
            chk("scb_reg", 32'(dout0), 32'(exp_q0.pop_front()));
         end
      end
   end

   // Fall-through mode: the popped word was on data_out before the edge.
   initial forever begin
      @(negedge clk);
      d1_snap = dout1;
      @(posedge clk);
      if (m_racc) begin
         if (exp_q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL scb_fwft: read with empty expected queue at t=%0t", $time);
         end else begin
            chk("scb_fwft", 32'(d1_snap), 32'(exp_q1.pop_front()));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
      step(0, 0, 0, 1, 8'h00);
      step(0, 0, 0, 1, 8'h00);

      // fill to full, then one write too many
      for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(i));
      step(1, 0, 0, 0, 8'h10);

      // drain, one read too many, then data_out must hold 0x0F
      for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'h00);
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      step(0, 0, 1, 0, 8'h00);

      // steady state at 10 entries across pointer wrap
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
      for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 8'(8'h4A + i));
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 8'h00);

      // fall-through single word
      step(1, 0, 0, 0, 8'hA5);
      step(0, 0, 0, 0, 8'h00);
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);

      // overflow clearing and set-wins-over-clear
      for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(8'h80 + i));
      step(1, 0, 0, 0, 8'hEE);
      step(0, 0, 1, 0, 8'h00);
      step(1, 0, 1, 0, 8'hEF);
      step(0, 0, 0, 0, 8'h00);
      step(1, 1, 0, 0, 8'h90);   // full + rd + wr: read only

      // reset mid-burst with wr_en high
      step(0, 0, 0, 1, 8'h00);
      step(0, 1, 1, 0, 8'h00);   // empty + rd: underflow
      step(1, 1, 0, 0, 8'h55);   // empty + rd + wr: write only
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'(8'h20 + i));
      step(1, 0, 0, 1, 8'h77);
      step(1, 0, 0, 0, 8'h3C);
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);

      // randomized traffic, fill-biased then drain-biased
      for (int i = 0; i < 500; i++) begin
         logic w, r, c, x;
         int bias;
         bias = ((i / 100) % 2 == 0) ? 70 : 30;
         w = ($urandom_range(0, 99) < bias);
         r = ($urandom_range(0, 99) < (100 - bias));
         c = ($urandom_range(0, 15) == 0);
         x = ($urandom_range(0, 199) == 0);
         step(w, r, c, x, 8'($urandom));
      end
      step(0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);

      chk("scb_reg_drained",  32'(exp_q0.size()), 32'd0);
      chk("scb_fwft_drained", 32'(exp_q1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
